eth_cfg_resp: RTL and testbench



---
 rtl/eth_cfg_pkg.sv | 25 ++
 rtl/eth_cfg_resp_mdc_gen.sv | 32 +++
 rtl/eth_cfg_resp.sv | 132 +++++++++++++
 tb/tb_eth_cfg_resp.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/eth_cfg_pkg.sv
// rtl/eth_cfg_pkg.sv - shared FSM states, MDIO frame constants and address field positions
package eth_cfg_pkg;

  typedef enum logic [2:0] {IDLE, PRE, ST_OP, ADDR, TA, DATA, DONE} mdio_state_e;

  localparam int         PRE_LEN   = 32;
  localparam int         FRAME_LEN = 64;
  localparam logic [1:0] ST        = 2'b01;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_RD     = 2'b10;
  localparam logic [1:0] TA_WR     = 2'b10;

  localparam int PHYAD_MSB = 9;
  localparam int PHYAD_LSB = 5;
  localparam int REGAD_MSB = 4;
  localparam int REGAD_LSB = 0;

  // Index of the last bit of each frame section within the 64-bit frame
  localparam logic [5:0] PRE_LAST  = 6'd31;
  localparam logic [5:0] STOP_LAST = 6'd35;
  localparam logic [5:0] ADDR_LAST = 6'd45;
  localparam logic [5:0] TA_LAST   = 6'd47;
  localparam logic [5:0] DATA_LAST = 6'd63;

endpackage

// File: rtl/eth_cfg_resp_mdc_gen.sv
// rtl/eth_cfg_resp_mdc_gen.sv - MDC divider with drive and sample strobes
module mdc_gen #(
  parameter int MDC_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic mdc,
  output logic drive_stb,
  output logic smp_stb
);

  localparam int            CW   = $clog2(2 * MDC_DIV);
  localparam logic [CW-1:0] HALF = CW'(MDC_DIV);
  localparam logic [CW-1:0] SMP  = CW'(MDC_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(2 * MDC_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn || !en)   cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

  // drive_stb closes a bit so the next low half starts with new data;
  // smp_stb marks the edge on which mdc goes high.
  assign mdc       = en && (cnt >= HALF);
  assign drive_stb = en && (cnt == LAST);
  assign smp_stb   = en && (cnt == SMP);

endmodule

// File: rtl/eth_cfg_resp.sv
// rtl/eth_cfg_resp.sv - usr_cfg responder: local register bank or clause-22 MDIO; option ETH_MDIO_PRE_SUPPRESS_EN
module eth_cfg_resp
  import eth_cfg_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 16,
  parameter int MDC_DIV        = 4,
  parameter int LOCAL_REGS     = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      usr_cfg_type,
  input  logic                      usr_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] usr_wr_addr,
  input  logic [REG_DATA_WIDTH-1:0] usr_wr_data,
  input  logic                      usr_rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] usr_rd_addr,
  output logic                      usr_rd_vld,
  output logic [REG_DATA_WIDTH-1:0] usr_rd_data,
  output logic                      busy,
  output logic                      mdc,
  output logic                      mdio_o,
  output logic                      mdio_oe,
  input  logic                      mdio_i
);

  localparam int IDX_W = $clog2(LOCAL_REGS);

  mdio_state_e               state, state_nxt, start_state;
  logic [5:0]                bit_cnt, start_bit;
  logic [FRAME_LEN-1:0]      frame;
  logic                      is_rd;
  logic [REG_DATA_WIDTH-1:0] rx_sr;
  logic [REG_DATA_WIDTH-1:0] bank [LOCAL_REGS];
  logic                      active, start_mdio, drive_stb, smp_stb;
  logic                      unused_addr_bits;

  assign active     = (state != IDLE) && (state != DONE);
  assign start_mdio = (state == IDLE) && usr_cfg_type && (usr_wr_en || usr_rd_en);
  assign unused_addr_bits = ^{usr_wr_addr[REG_ADDR_WIDTH-1:PHYAD_MSB+1],
                              usr_rd_addr[REG_ADDR_WIDTH-1:PHYAD_MSB+1]};

`ifdef ETH_MDIO_PRE_SUPPRESS_EN
  logic pre_done;

  // Only the first frame after reset carries the preamble
  always_ff @(posedge clk) begin
    if (!rstn)           pre_done <= 1'b0;
    else if (start_mdio) pre_done <= 1'b1;
  end

  assign start_state = pre_done ? ST_OP : PRE;
  assign start_bit   = pre_done ? 6'(PRE_LEN) : 6'd0;
`else
  assign start_state = PRE;
  assign start_bit   = 6'd0;
`endif

  mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc_gen (
    .clk       (clk),
    .rstn      (rstn),
    .en        (active),
    .mdc       (mdc),
    .drive_stb (drive_stb),
    .smp_stb   (smp_stb)
  );

  always_comb begin
    state_nxt = state;
    busy      = active;
    mdio_o    = 1'b1;
    mdio_oe   = 1'b0;
    case (state)
      IDLE: if (start_mdio) state_nxt = start_state;
      DONE: state_nxt = IDLE;
      default: begin
        mdio_o  = frame[6'd63 - bit_cnt];
        mdio_oe = !is_rd || (bit_cnt <= ADDR_LAST);
        if (drive_stb) begin
          case (bit_cnt)
            PRE_LAST:  state_nxt = ST_OP;
            STOP_LAST: state_nxt = ADDR;
            ADDR_LAST: state_nxt = TA;
            TA_LAST:   state_nxt = DATA;
            DATA_LAST: state_nxt = DONE;
            default:   state_nxt = state;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      frame       <= '0;
      is_rd       <= 1'b0;
      rx_sr       <= '0;
      usr_rd_vld  <= 1'b0;
      usr_rd_data <= '0;
      for (int i = 0; i < LOCAL_REGS; i++) bank[i] <= '0;
    end else begin
      state      <= state_nxt;
      usr_rd_vld <= 1'b0;
      if (state == IDLE) begin
        if (usr_wr_en && !usr_cfg_type) begin
          bank[usr_wr_addr[IDX_W-1:0]] <= usr_wr_data;
        end else if (usr_rd_en && !usr_wr_en && !usr_cfg_type) begin
          usr_rd_vld  <= 1'b1;
          usr_rd_data <= bank[usr_rd_addr[IDX_W-1:0]];
        end
        if (start_mdio) begin
          bit_cnt <= start_bit;
          is_rd   <= !usr_wr_en;
          frame   <= usr_wr_en
            ? {{PRE_LEN{1'b1}}, ST, OP_WR, usr_wr_addr[PHYAD_MSB:PHYAD_LSB],
               usr_wr_addr[REGAD_MSB:REGAD_LSB], TA_WR, usr_wr_data}
            : {{PRE_LEN{1'b1}}, ST, OP_RD, usr_rd_addr[PHYAD_MSB:PHYAD_LSB],
               usr_rd_addr[REGAD_MSB:REGAD_LSB], 2'b11, {REG_DATA_WIDTH{1'b1}}};
        end
      end
      if (active && drive_stb) bit_cnt <= bit_cnt + 6'd1;
      if ((state == DATA) && smp_stb) rx_sr <= {rx_sr[REG_DATA_WIDTH-2:0], mdio_i};
      if ((state == DATA) && drive_stb && (bit_cnt == DATA_LAST) && is_rd) begin
        usr_rd_vld  <= 1'b1;
        usr_rd_data <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_eth_cfg_resp.sv
// tb/tb_eth_cfg_resp.sv - randomized self-checking bench for eth_cfg_resp with a PHY and bank model
module tb_eth_cfg_resp;

  localparam int MDC_DIV = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        usr_cfg_type, usr_wr_en, usr_rd_en;
  logic [31:0] usr_wr_addr, usr_rd_addr;
  logic [15:0] usr_wr_data, usr_rd_data;
  logic        usr_rd_vld, busy, mdc, mdio_o, mdio_oe, mdio_i;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] bank_m  [8];
  logic [15:0] phy_mem [1024];
  bit          first_frame;

  always #5 clk = ~clk;

  eth_cfg_resp #(.REG_ADDR_WIDTH(32), .REG_DATA_WIDTH(16), .MDC_DIV(MDC_DIV), .LOCAL_REGS(8)) dut (
    .clk(clk), .rstn(rstn), .usr_cfg_type(usr_cfg_type),
    .usr_wr_en(usr_wr_en), .usr_wr_addr(usr_wr_addr), .usr_wr_data(usr_wr_data),
    .usr_rd_en(usr_rd_en), .usr_rd_addr(usr_rd_addr),
    .usr_rd_vld(usr_rd_vld), .usr_rd_data(usr_rd_data), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) bank_m[i] = 16'h0;
    first_frame = 1'b1;
  endtask

  task automatic local_wr(input logic [31:0] addr, input logic [15:0] data);
    usr_cfg_type = 1'b0; usr_wr_en = 1'b1; usr_wr_addr = addr; usr_wr_data = data;
    @(posedge clk); #1;
    usr_wr_en = 1'b0;
    bank_m[addr[2:0]] = data;
    chk("local_wr_busy", busy, 0);
    chk("local_wr_no_vld", usr_rd_vld, 0);
  endtask

  task automatic local_rd(input logic [31:0] addr);
    usr_cfg_type = 1'b0; usr_rd_en = 1'b1; usr_rd_addr = addr;
    @(posedge clk); #1;
    usr_rd_en = 1'b0;
    chk("local_rd_vld", usr_rd_vld, 1);
    chk("local_rd_data", usr_rd_data, bank_m[addr[2:0]]);
    chk("local_rd_busy", busy, 0);
    @(posedge clk); #1;
    chk("local_rd_vld_pulse", usr_rd_vld, 0);
  endtask

  // One MDIO transaction; inj_cyc injects a local write to index 5 at that
  // frame cycle, abort_bit pulses rstn during that frame bit (-1 disables).
  task automatic mdio_op(input bit rd, input logic [31:0] addr, input logic [15:0] wd,
                         input int inj_cyc, input int abort_bit);
    logic [9:0]  key;
    logic [15:0] pv;
    logic [63:0] exp_o, exp_oe, cap_o, cap_oe, mask, o_mask;
    int          nbits, rises, done_n, busy_n, vld_cnt, f;
    bit          prev_mdc;
    key = addr[9:0];
    pv  = phy_mem[key];
    nbits = 64;
`ifdef ETH_MDIO_PRE_SUPPRESS_EN
    if (!first_frame) nbits = 32;
`endif
    first_frame = 1'b0;
    exp_o  = {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), addr[9:5], addr[4:0], 2'b10, wd};
    exp_oe = rd ? {{46{1'b1}}, 18'b0} : {64{1'b1}};
    mask   = (nbits == 32) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
    o_mask = rd ? (mask & ~64'h3FFFF) : mask;
    cap_o = '0; cap_oe = '0;
    usr_cfg_type = 1'b1;
    if (rd) begin usr_rd_en = 1'b1; usr_rd_addr = addr; end
    else begin usr_wr_en = 1'b1; usr_wr_addr = addr; usr_wr_data = wd; end
    @(posedge clk); #1;
    usr_rd_en = 1'b0; usr_wr_en = 1'b0;
    rises = 0; done_n = 0; busy_n = 0; vld_cnt = 0; prev_mdc = 1'b0;
    for (int n = 1; n <= 1200; n++) begin
      if (!busy) begin done_n = n; break; end
      busy_n++;
      if (usr_rd_vld) vld_cnt++;
      if (mdc && !prev_mdc) begin
        f = rises + 64 - nbits;
        cap_o[63-f] = mdio_o; cap_oe[63-f] = mdio_oe;
        rises++;
      end
      prev_mdc = mdc;
      if (abort_bit >= 0 && rises == abort_bit + 1) begin
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
        chk("abort_busy", busy, 0);
        chk("abort_oe", mdio_oe, 0);
        chk("abort_mdc", mdc, 0);
        chk("abort_vld", usr_rd_vld, 0);
        chk("abort_mdio_o", mdio_o, 1);
        return;
      end
      if (n == inj_cyc) begin
        usr_cfg_type = 1'b0; usr_wr_en = 1'b1; usr_wr_addr = 32'd5; usr_wr_data = 16'h5555;
      end else begin
        usr_wr_en = 1'b0; usr_cfg_type = 1'b1;
      end
      f = rises + 64 - nbits;
      mdio_i = (rd && f >= 48 && f <= 63) ? pv[63-f] : 1'b1;
      @(posedge clk); #1;
    end
    mdio_i = 1'b1;
    chk("frame_latency", done_n, 1 + nbits * 2 * MDC_DIV);
    chk("busy_cycles", busy_n, nbits * 2 * MDC_DIV);
    chk("vld_while_busy", vld_cnt, 0);
    chk("mdio_o_stream", cap_o & o_mask, exp_o & o_mask);
    chk("mdio_oe_stream", cap_oe & mask, exp_oe & mask);
    chk("done_mdc", mdc, 0);
    chk("done_oe", mdio_oe, 0);
    chk("done_mdio_o", mdio_o, 1);
    chk("done_vld", usr_rd_vld, rd);
    if (rd) chk("mdio_rd_data", usr_rd_data, pv);
    else    phy_mem[key] = wd;
    @(posedge clk); #1;
    chk("vld_after_done", usr_rd_vld, 0);
  endtask

  initial begin
    rstn = 1'b0; usr_cfg_type = 1'b0; usr_wr_en = 1'b0; usr_rd_en = 1'b0;
    usr_wr_addr = '0; usr_rd_addr = '0; usr_wr_data = '0; mdio_i = 1'b1;
    for (int i = 0; i < 1024; i++) phy_mem[i] = 16'($urandom);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_vld", usr_rd_vld, 0);
    chk("rst_data", usr_rd_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mdc", mdc, 0);
    chk("rst_mdio_o", mdio_o, 1);
    chk("rst_mdio_oe", mdio_oe, 0);
    local_rd(32'd6);

    local_wr(32'd3, 16'hBEEF);
    local_rd(32'd3);

    mdio_op(1'b0, {22'd0, 5'h01, 5'h00}, 16'h1140, -1, -1);
    phy_mem[{5'h01, 5'h02}] = 16'h0141;
    mdio_op(1'b1, {22'd0, 5'h01, 5'h02}, 16'h0, -1, -1);

    local_wr(32'd5, 16'hA5A5);
    mdio_op(1'b0, {22'd0, 5'h03, 5'h11}, 16'h2222, 100, -1);
    local_rd(32'd5);

    usr_cfg_type = 1'b0; usr_wr_en = 1'b1; usr_rd_en = 1'b1;
    usr_wr_addr = 32'd1; usr_rd_addr = 32'd1; usr_wr_data = 16'h00AA;
    @(posedge clk); #1;
    usr_wr_en = 1'b0; usr_rd_en = 1'b0;
    bank_m[1] = 16'h00AA;
    chk("wr_rd_same_cycle_vld", usr_rd_vld, 0);
    @(posedge clk); #1;
    chk("wr_rd_same_cycle_vld2", usr_rd_vld, 0);
    local_rd(32'd1);

    mdio_op(1'b1, {22'd0, 5'h04, 5'h07}, 16'h0, -1, 40);
    local_rd(32'd3);
    mdio_op(1'b1, {22'd0, 5'h04, 5'h07}, 16'h0, -1, -1);
    mdio_op(1'b1, {22'd0, 5'h01, 5'h00}, 16'h0, -1, -1);

    for (int k = 0; k < 30; k++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 5);
      a  = $urandom;
      case (op)
        0, 1: local_wr(a, 16'($urandom));
        2, 3: local_rd(a);
        4:    mdio_op(1'b0, a, 16'($urandom), -1, -1);
        default: mdio_op(1'b1, a, 16'h0, -1, -1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
